osnt_rx_stamp_insert: RTL
=========================

// Module: osnt_rx_stamp_insert
// PURPOSE
//  Consumer of the free-running 64-bit stamp counter. Sits on the RX AXI4-Stream path directly after the MAC/port input.
//  Captures the counter value when each packet's first beat arrives and writes it into TUSER of that beat.
//  Downstream capture/monitor logic gets a per-packet arrival timestamp.
// PARAMETERS
//  C_M_AXIS_DATA_WIDTH   256  TDATA width (bits); TSTRB width = /8
//  C_S_AXIS_TUSER_WIDTH  128  TUSER width; must be >= TS_OFFSET+TIMESTAMP_WIDTH
//  TIMESTAMP_WIDTH       64   width of stamp_counter and of the inserted field
//  TS_OFFSET             32   LSB position of the timestamp field in TUSER
// PORTS
//  axi_aclk        in   1      single clock, all logic rising-edge
//  axi_resetn      in   1      synchronous, active-low reset
//  stamp_counter   in   64     free-running timestamp, same clock domain
//  stamp_en        in   1      1 = insert stamp; 0 = TUSER passes untouched (quasi-static config)
//  s_axis_tdata    in   256    input stream data
//  s_axis_tstrb    in   32     input byte strobes
//  s_axis_tuser    in   128    input sideband ([15:0] len, [31:16] port, upper bits free)
//  s_axis_tvalid   in   1      input valid
//  s_axis_tready   out  1      input ready
//  s_axis_tlast    in   1      input end of packet
//  m_axis_tdata/tstrb/tuser/tvalid/tlast  out  as s_*  output stream
//  m_axis_tready   in   1      output ready
//  pkt_cnt         out  32     stamped-packet count (only with OSNT_STAMP_PKT_CNT_EN)
// BEHAVIOUR
//  Reset: m_axis_tvalid=0, s_axis_tready=0 during reset, 1 on the first cycle after. FSM=SOF, skid empty, pkt_cnt=0.
//  Handshake: AXI4-Stream. Beat moves when valid&ready. Output held stable while m_tvalid&!m_tready.
//  Latency: 1 cycle input->output. Full throughput (1 beat/cycle) under continuous m_tready.
//  FSM: SOF  -> IN_PKT on accepted beat with tlast=0. Accepted beat with tlast=1 stays in SOF (single-beat pkt).
//       IN_PKT -> SOF on accepted beat with tlast=1.
//  Capture: in SOF, the first cycle s_tvalid=1 latches stamp_counter into ts_hold and sets ts_held.
//       Later stall cycles do not re-latch. ts_held clears when the beat is accepted.
//       The stamp therefore marks arrival, not acceptance; backpressure adds no skew.
//  Insert: on the SOF beat with stamp_en=1, m_tuser[TS_OFFSET+:64] = ts_hold. All other TUSER bits are passed through.
//       Non-SOF beats and stamp_en=0: TUSER is bit-exact pass-through. TDATA/TSTRB/TLAST always bit-exact.
//  stamp_en is sampled on the SOF beat. Changing it mid-packet has no effect until the next packet.
//  Counter wrap: stamp_counter 0xFFFF..FF->0 is copied raw; no correction.
//  Simultaneous: an output handshake and a new SOF input in the same cycle are both honoured; no bubble.
//  Reset mid-packet: packet is abandoned (no tlast emitted). FSM returns to SOF. Next beat is treated as SOF.
// CONFIGURATION
//  OSNT_STAMP_PKT_CNT_EN defined: pkt_cnt increments on each accepted output SOF beat with stamp_en=1.
//       It wraps 0xFFFFFFFF->0 and is cleared by reset.
//  Undefined: pkt_cnt port absent, no counter logic. All other behaviour is identical.
// STRUCTURE
//  Shared header osnt_stamp_defs.vh:
//       TUSER field offsets (LEN, SPT, DPT, TS_OFFSET), TIMESTAMP_WIDTH default, FSM state encodings SOF/IN_PKT.
//  Sub-module osnt_axis_reg_slice: 2-entry skid register, full-throughput valid/ready decoupling.
//       Instantiated once on the output. Top holds the FSM, capture and insert mux.
// TESTING
//  1. Single 4-beat pkt, stamp_counter=0x10 at first s_tvalid, no stall
//       -> beat0 m_tuser[95:32]=0x10; beats1-3 tuser unchanged; tlast on beat3; latency 1.
//  2. SOF valid at counter=0x100, m_tready held 0 for 7 cycles
//       -> stamp still 0x100; data stable throughout stall.
//  3. Back-to-back 1-beat pkts, counter 0x200,0x201,0x202
//       -> stamps 0x200/0x201/0x202; 1 beat/cycle, no bubbles.
//  4. stamp_en=0, s_tuser=0xDEADBEEF_..._CAFE -> m_tuser identical to s_tuser on all beats.
//  5. Counter 0xFFFF_FFFF_FFFF_FFFF at SOF -> field=all-ones; next pkt at 0x0 -> field=0.
//  6. axi_resetn low on beat 2 of 5 -> m_tvalid=0 next cycle.
//       Next pkt after reset stamped on its beat0; pkt_cnt=0 then 1 (with OSNT_STAMP_PKT_CNT_EN).

Source files
------------

// File: rtl/osnt_rx_stamp_insert_pkg.sv
// Shared definitions for the RX arrival-timestamp inserter.
// TUSER field layout, default widths and FSM states.
package osnt_rx_stamp_insert_pkg;

  localparam int DATA_W  = 256;
  localparam int USER_W  = 128;
  localparam int TS_W    = 64;
  localparam int TS_OFF  = 32;

  localparam int LEN_OFF = 0;
  localparam int SPT_OFF = 16;
  localparam int DPT_OFF = 24;

  typedef enum logic {
    SOF    = 1'b0,
    IN_PKT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/osnt_rx_stamp_insert_if.sv
// AXI4-Stream bundle used on both sides of the stamp inserter.
// master drives payload/valid, slave drives ready.
interface osnt_rx_stamp_insert_if
  import osnt_rx_stamp_insert_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int UW = USER_W
);

  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tstrb;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (
    output tdata,
    output tstrb,
    output tuser,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tstrb,
    input  tuser,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/osnt_rx_stamp_insert_reg_slice.sv
// Two-entry skid register: 1-cycle latency, full throughput,
// ready is a pure flop so no combinational path crosses it.
module osnt_rx_stamp_insert_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic         rdy_q, rdy_d;
  logic         in_fire;
  logic         out_fire;

  assign in_fire  = s_valid & rdy_q;
  assign out_fire = main_vld_q & m_ready;

  assign s_ready = rdy_q;
  assign m_valid = main_vld_q;
  assign m_data  = main_q;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (skid_vld_q) begin
      if (out_fire) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!main_vld_q || out_fire) begin
        main_d     = s_data;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = s_data;
        skid_vld_d = 1'b1;
      end
    end else if (out_fire) begin
      main_vld_d = 1'b0;
    end
    rdy_d = ~skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

endmodule

// File: rtl/osnt_rx_stamp_insert.sv
// Writes the arrival time of each packet's first beat into TUSER.
// OSNT_STAMP_PKT_CNT_EN adds the pkt_cnt stamped-packet counter.
module osnt_rx_stamp_insert
  import osnt_rx_stamp_insert_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = DATA_W,
  parameter int C_S_AXIS_TUSER_WIDTH = USER_W,
  parameter int TIMESTAMP_WIDTH      = TS_W,
  parameter int TS_OFFSET            = TS_OFF
) (
  input  logic                       axi_aclk,
  input  logic                       axi_resetn,
  input  logic [TIMESTAMP_WIDTH-1:0] stamp_counter,
  input  logic                       stamp_en,
  osnt_rx_stamp_insert_if.slave      s_axis,
  osnt_rx_stamp_insert_if.master     m_axis
`ifdef OSNT_STAMP_PKT_CNT_EN
  ,
  output logic [31:0]                pkt_cnt
`endif
);

  localparam int DW = C_M_AXIS_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int TW = TIMESTAMP_WIDTH;
`ifdef OSNT_STAMP_PKT_CNT_EN
  localparam int FW = 1;
`else
  localparam int FW = 0;
`endif
  localparam int PW = DW + SW + UW + 1 + FW;

  rx_state_e     state_q, state_d;
  logic [TW-1:0] ts_hold_q, ts_hold_d;
  logic          ts_held_q, ts_held_d;
  logic          in_fire;
  logic          sof;
  logic [TW-1:0] stamp;
  logic [UW-1:0] user_ins;
  logic [PW-1:0] s_pay;
  logic [PW-1:0] m_pay;

  assign in_fire = s_axis.tvalid & s_axis.tready;
  assign sof     = (state_q == SOF);

  always_comb begin
    state_d   = state_q;
    ts_hold_d = ts_hold_q;
    ts_held_d = ts_held_q;
    unique case (state_q)
      SOF: begin
        if (s_axis.tvalid && !ts_held_q) begin
          ts_hold_d = stamp_counter;
          ts_held_d = 1'b1;
        end
        if (in_fire) begin
          ts_held_d = 1'b0;
          if (!s_axis.tlast) state_d = IN_PKT;
        end
      end
      IN_PKT: begin
        if (in_fire && s_axis.tlast) state_d = SOF;
      end
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state_q   <= SOF;
      ts_held_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ts_held_q <= ts_held_d;
    end
  end

  always_ff @(posedge axi_aclk) begin
    ts_hold_q <= ts_hold_d;
  end

  // Beat accepted on its first valid cycle has no held value yet.
  assign stamp = ts_held_q ? ts_hold_q : stamp_counter;

  always_comb begin
    user_ins = s_axis.tuser;
    if (sof && stamp_en) user_ins[TS_OFFSET +: TW] = stamp;
  end

`ifdef OSNT_STAMP_PKT_CNT_EN
  assign s_pay = {sof & stamp_en, s_axis.tlast, user_ins,
                  s_axis.tstrb, s_axis.tdata};
`else
  assign s_pay = {s_axis.tlast, user_ins,
                  s_axis.tstrb, s_axis.tdata};
`endif

  osnt_rx_stamp_insert_reg_slice #(
    .W (PW)
  ) u_slice (
    .clk     (axi_aclk),
    .rst_n   (axi_resetn),
    .s_valid (s_axis.tvalid),
    .s_ready (s_axis.tready),
    .s_data  (s_pay),
    .m_valid (m_axis.tvalid),
    .m_ready (m_axis.tready),
    .m_data  (m_pay)
  );

  assign m_axis.tdata = m_pay[DW-1:0];
  assign m_axis.tstrb = m_pay[DW +: SW];
  assign m_axis.tuser = m_pay[DW+SW +: UW];
  assign m_axis.tlast = m_pay[DW+SW+UW];

`ifdef OSNT_STAMP_PKT_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Counts stamped packets as they leave, wrapping naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (m_axis.tvalid && m_axis.tready && m_pay[PW-1])
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) cnt_q <= 32'd0;
    else             cnt_q <= cnt_d;
  end

  assign pkt_cnt = cnt_q;
`endif

endmodule
